// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned DAT_WIDTH_DEF = 8;
    localparam int unsigned BURST_MAX_DEF = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned id_width(input int unsigned n_req);
        return clog2(n_req);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned burst_max);
        return clog2(burst_max) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_id, wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  last_id,
    output logic [ID_W-1:0]  pick_id,
    output logic             any_req
);

    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_s;
        idx     = 0;
        idx_s   = '0;
        pick_id = '0;
        any_req = |req_valid;
        // Scan farthest offset first so the nearest requester after last_id overwrites last.
        for (int unsigned off = N_REQ; off >= 1; off--) begin
            idx   = (int'(last_id) + off) % N_REQ;
            idx_s = ID_W'(idx);
            if (req_valid[idx_s]) pick_id = idx_s;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers, bursts of up to BURST_MAX.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned DAT_WIDTH = DAT_WIDTH_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DAT_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr,
    output logic [DAT_WIDTH-1:0]       fifo_w_data,
    output logic [clog2(N_REQ)-1:0]    grant_id,
    output logic                       busy
);

    localparam int unsigned ID_W  = id_width(N_REQ);
    localparam int unsigned CNT_W = cnt_width(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [ID_W-1:0]  ID_RST   = ID_W'(N_REQ - 1);

    arb_state_e           state_q;
    logic [ID_W-1:0]      cur_id_q;
    logic [ID_W-1:0]      last_id_q;
    logic [CNT_W-1:0]     burst_cnt_q;
    logic [ID_W-1:0]      pick_id;
    logic                 any_req;
    logic                 cur_valid;
    logic [DAT_WIDTH-1:0] cur_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .last_id   (last_id_q),
        .pick_id   (pick_id),
        .any_req   (any_req)
    );

    assign cur_valid = req_valid[cur_id_q];
    assign cur_data  = req_data[int'(cur_id_q)*DAT_WIDTH +: DAT_WIDTH];

    always_comb begin
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_w_data = '0;
        if (state_q == ST_GRANT) begin
            req_ready[cur_id_q] = ~fifo_full;
            fifo_wr             = cur_valid & ~fifo_full;
            fifo_w_data         = cur_data;
        end
    end

    assign grant_id = cur_id_q;
    assign busy     = (state_q == ST_GRANT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_id_q    <= '0;
            last_id_q   <= ID_RST;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        cur_id_q    <= pick_id;
                        burst_cnt_q <= '0;
                        state_q     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!cur_valid) begin
                        last_id_q <= cur_id_q;
                        state_q   <= ST_IDLE;
                    end else if (fifo_wr) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                        if (burst_cnt_q == CNT_LAST) begin
                            last_id_q <= cur_id_q;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomised checks of fifo_wr_arbiter with N_REQ=4, DAT_WIDTH=8, BURST_MAX=4.
module tb_fifo_wr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam int unsigned B = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wr;
    logic [W-1:0]   fifo_w_data;
    logic [1:0]     grant_id;
    logic           busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DAT_WIDTH (W),
        .BURST_MAX (B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int unsigned e_busy, input int unsigned e_id,
                           input int unsigned e_wr, input int unsigned e_data, input int unsigned e_rdy);
        check_eq({tag, ".busy"},  busy,        e_busy);
        check_eq({tag, ".gid"},   grant_id,    e_id);
        check_eq({tag, ".wr"},    fifo_wr,     e_wr);
        check_eq({tag, ".data"},  fifo_w_data, e_data);
        check_eq({tag, ".ready"}, req_ready,   e_rdy);
    endtask

    task set_data(input int unsigned i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task next_cyc();
        @(posedge clk);
        #1;
    endtask

    task samp();
        @(negedge clk);
    endtask

    task do_reset();
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
    endtask

    int unsigned seq     [N];
    int unsigned exp_seq [N];
    logic [N-1:0] acc;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        next_cyc();
        next_cyc();
        samp();
        chk_out("rst", 0, 0, 0, 0, 0);
        next_cyc();
        reset = 1'b0;

        // Single producer, three words then valid drops
        req_valid = 4'b0001;
        set_data(0, 8'h11);
        samp();
        chk_out("s1_idle", 0, 0, 0, 0, 0);
        next_cyc();
        samp();
        chk_out("s1_w0", 1, 0, 1, 8'h11, 4'b0001);
        next_cyc();
        set_data(0, 8'h22);
        samp();
        chk_out("s1_w1", 1, 0, 1, 8'h22, 4'b0001);
        next_cyc();
        set_data(0, 8'h33);
        samp();
        chk_out("s1_w2", 1, 0, 1, 8'h33, 4'b0001);
        next_cyc();
        req_valid = 4'b0000;
        samp();
        chk_out("s1_drop", 1, 0, 0, 8'h33, 4'b0001);
        next_cyc();
        samp();
        chk_out("s1_end", 0, 0, 0, 0, 0);

        // last_id is 0 with 0 and 3 valid and 1 idle: 3 must win, then 0
        next_cyc();
        req_valid = 4'b1001;
        set_data(0, 8'hA0);
        set_data(3, 8'hD3);
        samp();
        chk_out("s4_idle", 0, 0, 0, 0, 0);
        next_cyc();
        samp();
        chk_out("s4_g3", 1, 3, 1, 8'hD3, 4'b1000);
        next_cyc();
        req_valid = 4'b0001;
        samp();
        chk_out("s4_drop3", 1, 3, 0, 8'hD3, 4'b1000);
        next_cyc();
        samp();
        check_eq("s4_arb.busy", busy, 0);
        next_cyc();
        samp();
        chk_out("s4_g0", 1, 0, 1, 8'hA0, 4'b0001);
        next_cyc();
        req_valid = 4'b0000;
        next_cyc();

        // All producers valid: order 0,1,2,3,0 with 4 words each and one idle cycle between
        do_reset();
        for (int unsigned i = 0; i < N; i++) begin
            seq[i] = 0;
            set_data(i, 8'(i * 16));
        end
        req_valid = 4'b1111;
        for (int unsigned r = 0; r < 5; r++) begin
            int unsigned g;
            g = r % N;
            samp();
            check_eq("s2_idle.busy", busy, 0);
            next_cyc();
            for (int unsigned k = 0; k < B; k++) begin
                samp();
                chk_out("s2_w", 1, g, 1, g * 16 + (r / N) * B + k, 1 << g);
                next_cyc();
                seq[g]++;
                set_data(g, 8'(g * 16 + seq[g]));
            end
        end
        req_valid = 4'b0000;
        next_cyc();

        // Full stall during producer 2's second word
        do_reset();
        req_valid = 4'b0100;
        set_data(2, 8'h20);
        samp();
        check_eq("s3_idle.busy", busy, 0);
        next_cyc();
        samp();
        chk_out("s3_w0", 1, 2, 1, 8'h20, 4'b0100);
        next_cyc();
        set_data(2, 8'h21);
        fifo_full = 1'b1;
        for (int unsigned c = 0; c < 5; c++) begin
            samp();
            chk_out("s3_stall", 1, 2, 0, 8'h21, 4'b0000);
            next_cyc();
        end
        fifo_full = 1'b0;
        for (int unsigned k = 1; k < B; k++) begin
            samp();
            chk_out("s3_resume", 1, 2, 1, 8'h20 + k, 4'b0100);
            next_cyc();
            set_data(2, 8'(8'h20 + k + 1));
        end
        samp();
        check_eq("s3_done.busy", busy, 0);
        req_valid = 4'b0000;
        next_cyc();

        // Asynchronous reset in the middle of a burst
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'h51);
        next_cyc();
        samp();
        chk_out("s5_w0", 1, 1, 1, 8'h51, 4'b0010);
        next_cyc();
        set_data(1, 8'h52);
        reset = 1'b1;
        #1;
        chk_out("s5_rst", 0, 0, 0, 0, 0);
        next_cyc();
        reset = 1'b0;
        req_valid = 4'b0011;
        set_data(0, 8'h50);
        samp();
        check_eq("s5_idle.busy", busy, 0);
        next_cyc();
        samp();
        chk_out("s5_first", 1, 0, 1, 8'h50, 4'b0001);
        next_cyc();
        req_valid = 4'b0000;
        next_cyc();

        // Randomised producers and full flag with a per-producer ordering scoreboard
        do_reset();
        for (int unsigned i = 0; i < N; i++) begin
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        for (int unsigned c = 0; c < 10000; c++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
                set_data(i, 8'(i * 32 + (seq[i] % 32)));
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            samp();
            acc = req_ready & req_valid;
            check_eq("rnd_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
            check_eq("rnd_wr_full", fifo_wr & fifo_full, 0);
            check_eq("rnd_acc_wr", |acc, fifo_wr);
            if (fifo_wr) begin
                check_eq("rnd_data", fifo_w_data, 8'(grant_id * 32 + (exp_seq[grant_id] % 32)));
                exp_seq[grant_id]++;
            end
            next_cyc();
            for (int unsigned i = 0; i < N; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                end
            end
        end
        for (int unsigned i = 0; i < N; i++) check_eq("rnd_count", exp_seq[i], seq[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
